// File: rtl/mul_256b_seq.sv
`default_nettype none
// ============================================================================
// Module   : mul_256b_seq (with mul_128b_fw_ir)
// Brief    : 256x256 -> 512-bit unsigned multiplier built from four passes
//            through one 128-bit full-word multiplier, with valid/ready on
//            both the request and the result side.
// Revision : 1.0
// ============================================================================

module mul_128b_fw_ir (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] a,
    input  logic [127:0] b,
    output logic [255:0] product,
    output logic         done
);
    logic [127:0] a_q;
    logic [127:0] b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            done <= 1'b0;
        end else begin
            a_q  <= a;
            b_q  <= b;
            done <= start;
        end
    end

    assign product = {128'd0, a_q} * {128'd0, b_q};
endmodule

module mul_256b_seq #(
    parameter int MUL_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_vld_i,
    output logic         req_rdy_o,
    input  logic [255:0] req_a_i,
    input  logic [255:0] req_b_i,
    output logic         res_vld_o,
    input  logic         res_rdy_i,
    output logic [511:0] res_r_o,
    output logic         busy_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [255:0] a_lat;
    logic [255:0] b_lat;
    logic [511:0] acc;
    logic [511:0] addend;
    logic [1:0]   cnt;
    logic         accept;
    logic         issue;

    logic [MUL_LAT-1:0]      pipe_vld;
    logic [MUL_LAT-1:0][1:0] pipe_idx;
    logic                    out_vld;
    logic [1:0]              out_idx;

    logic [127:0] mul_a;
    logic [127:0] mul_b;
    logic [255:0] mul_p;
    logic [255:0] prod;
    logic         mul_done;
    logic         unused_done;

    mul_128b_fw_ir u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (issue),
        .a       (mul_a),
        .b       (mul_b),
        .product (mul_p),
        .done    (mul_done)
    );

    // Product timing is tracked by pipe_vld alone, so the core's done is not needed.
    assign unused_done = mul_done;

    generate
        if (MUL_LAT == 1) begin : g_prod_direct
            assign prod = mul_p;
        end else begin : g_prod_pipe
            logic [MUL_LAT-2:0][255:0] p_sr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_sr <= '0;
                end else begin
                    p_sr[0] <= mul_p;
                    for (int i = 1; i < MUL_LAT - 1; i++) begin
                        p_sr[i] <= p_sr[i-1];
                    end
                end
            end

            assign prod = p_sr[MUL_LAT-2];
        end
    endgenerate

    assign out_vld = pipe_vld[MUL_LAT-1];
    assign out_idx = pipe_idx[MUL_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_rdy_o = 1'b0;
        res_vld_o = 1'b0;
        res_r_o   = '0;
        busy_o    = 1'b1;
        accept    = 1'b0;
        issue     = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        case (state)
            IDLE: begin
                req_rdy_o = 1'b1;
                busy_o    = 1'b0;
                accept    = req_vld_i;
                if (req_vld_i) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                // cnt[0] selects the A half, cnt[1] the B half: aLbL, aHbL, aLbH, aHbH
                mul_a = cnt[0] ? a_lat[255:128] : a_lat[127:0];
                mul_b = cnt[1] ? b_lat[255:128] : b_lat[127:0];
                if (cnt == 2'd3) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_vld && (out_idx == 2'd3)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                res_vld_o = 1'b1;
                res_r_o   = acc;
                if (res_rdy_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        addend = {128'd0, prod, 128'd0};
        case (out_idx)
            2'd0:    addend = {256'd0, prod};
            2'd3:    addend = {prod, 256'd0};
            default: addend = {128'd0, prod, 128'd0};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lat    <= '0;
            b_lat    <= '0;
            acc      <= '0;
            cnt      <= 2'd0;
            pipe_vld <= '0;
            pipe_idx <= '0;
        end else begin
            pipe_vld[0] <= issue;
            pipe_idx[0] <= cnt;
            for (int i = 1; i < MUL_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end

            if (accept) begin
                a_lat <= req_a_i;
                b_lat <= req_b_i;
                cnt   <= 2'd0;
            end else if (issue) begin
                cnt <= cnt + 2'd1;
            end

            // Partial sums never exceed the final product, so the add cannot wrap.
            if (accept) begin
                acc <= '0;
            end else if (out_vld) begin
                acc <= acc + addend;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mul_256b_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_256b_seq
// Brief    : Directed-vector bench for mul_256b_seq at MUL_LAT=1 and MUL_LAT=3.
// Revision : 1.0
// ============================================================================

module tb_mul_256b_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         sel = 1'b0;
    logic         req_vld = 1'b0;
    logic         res_rdy = 1'b0;
    logic [255:0] req_a = '0;
    logic [255:0] req_b = '0;

    logic         rdy1, vld1, busy1, rdy3, vld3, busy3;
    logic [511:0] r1, r3;
    logic         req_rdy, res_vld, busy;
    logic [511:0] res_r;

    assign req_rdy = sel ? rdy3  : rdy1;
    assign res_vld = sel ? vld3  : vld1;
    assign busy    = sel ? busy3 : busy1;
    assign res_r   = sel ? r3    : r1;

    mul_256b_seq #(.MUL_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_vld_i(req_vld & ~sel), .req_rdy_o(rdy1),
        .req_a_i(req_a), .req_b_i(req_b),
        .res_vld_o(vld1), .res_rdy_i(res_rdy & ~sel),
        .res_r_o(r1), .busy_o(busy1)
    );

    mul_256b_seq #(.MUL_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_vld_i(req_vld & sel), .req_rdy_o(rdy3),
        .req_a_i(req_a), .req_b_i(req_b),
        .res_vld_o(vld3), .res_rdy_i(res_rdy & sel),
        .res_r_o(r3), .busy_o(busy3)
    );

    typedef struct {
        logic [255:0] a;
        logic [255:0] b;
        logic [511:0] exp;
    } vec_t;

    vec_t vt[8];
    int   n_vec = 0;
    int   n_err = 0;
    int   lat_exp = 6;
    int   lat_cfg = 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (MUL_LAT=%0d): got %h required %h", name, lat_cfg, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_vld = 1'b0; res_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called just after the accepting posedge; returns cycles until res_vld at a negedge.
    task automatic wait_result(output int lat, output bit rdy_ok);
        lat = 1; rdy_ok = 1'b1;
        @(negedge clk);
        req_vld = 1'b0; req_a = rand256(); req_b = rand256();
        while (!res_vld && lat < 40) begin
            if (req_rdy || !busy) rdy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (req_rdy || !busy) rdy_ok = 1'b0;
    endtask

    task automatic run_op(input logic [255:0] a, input logic [255:0] b,
                          output logic [511:0] r, output int lat, output bit rdy_ok);
        bit ok2;
        @(negedge clk);
        req_a = a; req_b = b; req_vld = 1'b1; res_rdy = 1'b0;
        ok2 = req_rdy;
        @(posedge clk);
        wait_result(lat, rdy_ok);
        rdy_ok = rdy_ok & ok2;
        r = res_r;
        res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
    endtask

    task automatic bp_test();
        logic [511:0] hold;
        logic [255:0] c, d;
        bit           stable, ok;
        int           lat;
        c = 256'd123456789;
        d = {128'd1, 128'd3};
        @(negedge clk);
        req_a = 256'd11; req_b = 256'd13; req_vld = 1'b1; res_rdy = 1'b0;
        @(posedge clk);
        wait_result(lat, ok);
        hold = res_r;
        check("bp_result", hold, 512'd143);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_vld = 1'b1; req_a = c; req_b = d;
            if (!res_vld || res_r !== hold || req_rdy) stable = 1'b0;
        end
        check("bp_hold_stable", {511'd0, stable}, 512'd1);
        res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
        check("bp_idle_after_release", {510'd0, req_rdy, res_vld}, 512'd2);
        @(posedge clk);
        wait_result(lat, ok);
        check("bp_pending_latency", 512'(lat), 512'(lat_exp));
        check("bp_pending_result", res_r, {256'd0, c} * {256'd0, d});
        res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
    endtask

    task automatic reset_test();
        logic [511:0] r;
        int           lat;
        bit           ok, quiet;
        @(negedge clk);
        req_a = 256'd7; req_b = 256'd9; req_vld = 1'b1; res_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_vld = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_req_rdy", {511'd0, req_rdy}, 512'd1);
        check("rst_mid_res_vld", {511'd0, res_vld}, 512'd0);
        check("rst_mid_busy", {511'd0, busy}, 512'd0);
        check("rst_mid_res_r", res_r, 512'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_vld || busy || !req_rdy) quiet = 1'b0;
        end
        res_rdy = 1'b0;
        check("rst_no_residue", {511'd0, quiet}, 512'd1);
        run_op(256'd2, 256'd4, r, lat, ok);
        check("rst_after_result", r, 512'd8);
        check("rst_after_latency", 512'(lat), 512'(lat_exp));
    endtask

    task automatic random_test(input int n);
        logic [511:0] q[$];
        logic [511:0] e;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        while (got < n && cyc < n * 40) begin
            @(negedge clk);
            cyc++;
            res_rdy = 1'($urandom_range(0, 1));
            if (res_vld && res_rdy) begin
                if (q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rand_spurious (MUL_LAT=%0d): result %h with none outstanding", lat_cfg, res_r);
                end else begin
                    e = q.pop_front();
                    check("rand_result", res_r, e);
                end
                got++;
            end
            if (sent < n) begin
                req_vld = 1'b1; req_a = rand256(); req_b = rand256();
                if (req_rdy) begin
                    q.push_back({256'd0, req_a} * {256'd0, req_b});
                    sent++;
                end
            end else begin
                req_vld = 1'b0;
            end
        end
        req_vld = 1'b0; res_rdy = 1'b0;
        check("rand_count", 512'(got), 512'(n));
        check("rand_queue_empty", 512'(q.size()), 512'd0);
    endtask

    initial begin
        logic [511:0] r;
        int           lat;
        bit           ok;

        vt[0] = '{256'd3, 256'd5, 512'd15};
        vt[1] = '{256'd1 << 128, 256'd1 << 128, 512'd1 << 256};
        vt[2] = '{256'd1 << 255, 256'd2, 512'd1 << 256};
        vt[3] = '{~256'd0, ~256'd0, {{255{1'b1}}, {256{1'b0}}, 1'b1}};
        vt[4] = '{256'd0, ~256'd0, 512'd0};
        vt[5] = '{{128'd0, ~128'd0}, {128'd0, ~128'd0}, {256'd0, {127{1'b1}}, {128{1'b0}}, 1'b1}};
        vt[6] = '{256'd1, ~256'd0, {256'd0, ~256'd0}};
        vt[7] = '{~256'd0, 256'd2, {255'd0, {256{1'b1}}, 1'b0}};

        for (int s = 0; s < 2; s++) begin
            sel     = 1'(s);
            lat_cfg = (s == 0) ? 1 : 3;
            lat_exp = 5 + lat_cfg;
            do_reset();
            check("reset_req_rdy", {511'd0, req_rdy}, 512'd1);
            check("reset_res_vld", {511'd0, res_vld}, 512'd0);
            check("reset_busy", {511'd0, busy}, 512'd0);
            check("reset_res_r", res_r, 512'd0);

            for (int i = 0; i < 8; i++) begin
                run_op(vt[i].a, vt[i].b, r, lat, ok);
                check($sformatf("vec%0d_result", i), r, vt[i].exp);
                check($sformatf("vec%0d_latency", i), 512'(lat), 512'(lat_exp));
                check($sformatf("vec%0d_rdy_low_busy_high", i), {511'd0, ok}, 512'd1);
            end

            bp_test();
            reset_test();
            random_test(1000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
